// File: rtl/pipe_stage_register_if.sv
// pipe_stage_register_if: control/payload bundle for pipe_stage_register; StallCount/FlushCount exist only with PIPE_STAGE_STATS_EN
interface pipe_stage_register_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 1
);
  logic                         StageWrite;
  logic                         Flush;
  logic                         InValid;
  logic [DATA_W-1:0]            InInstruction;
  logic [PC_W-1:0]              InPCAddResult;
  logic                         OutValid;
  logic [DATA_W-1:0]            OutInstruction;
  logic [PC_W-1:0]              OutPCAddResult;
  logic [$clog2(DEPTH+1)-1:0]   Occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]                  StallCount;
  logic [31:0]                  FlushCount;
  modport master (output StageWrite, Flush, InValid, InInstruction, InPCAddResult,
                  input  OutValid, OutInstruction, OutPCAddResult, Occupancy, StallCount, FlushCount);
  modport slave  (input  StageWrite, Flush, InValid, InInstruction, InPCAddResult,
                  output OutValid, OutInstruction, OutPCAddResult, Occupancy, StallCount, FlushCount);
`else
  modport master (output StageWrite, Flush, InValid, InInstruction, InPCAddResult,
                  input  OutValid, OutInstruction, OutPCAddResult, Occupancy);
  modport slave  (input  StageWrite, Flush, InValid, InInstruction, InPCAddResult,
                  output OutValid, OutInstruction, OutPCAddResult, Occupancy);
`endif
endinterface

// File: rtl/pipe_stage_register.sv
// pipe_stage_register: DEPTH-deep valid/payload/PC+4 pipeline register with stall, flush and occupancy; PIPE_STAGE_STATS_EN adds stall/flush counters
module pipe_stage_register #(
  parameter int          DATA_W    = 32,
  parameter int          PC_W      = 32,
  parameter int          DEPTH     = 1,
  parameter logic [31:0] NOP_VALUE = 32'h0000_0000
) (
  input logic                  Clk,
  input logic                  Reset,
  pipe_stage_register_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_VALUE);
  logic             w_clear;
  logic [DEPTH-1:0] w_valid_nxt;
  logic [OCC_W-1:0] w_occ_nxt, r_occ;
  assign w_clear = Reset | bus.Flush;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic              r_v, w_v;
    logic [DATA_W-1:0] r_d, w_d;
    logic [PC_W-1:0]   r_p, w_p;
    if (i == 0) begin : g_head
      assign w_v = bus.InValid;
      assign w_d = bus.InInstruction;
      assign w_p = bus.InPCAddResult;
    end else begin : g_tail
      assign w_v = g_stage[i-1].r_v;
      assign w_d = g_stage[i-1].r_d;
      assign w_p = g_stage[i-1].r_p;
    end
    assign w_valid_nxt[i] = w_clear ? 1'b0 : bus.StageWrite ? w_v : r_v;
    always_ff @(posedge Clk) begin
      if (w_clear) begin
        r_v <= 1'b0;
        r_d <= NOP;
        r_p <= '0;
      end else if (bus.StageWrite) begin
        r_v <= w_v;
        r_d <= w_d;
        r_p <= w_p;
      end
    end
  end
  // Occupancy is taken from next-state valids so it lines up with the stages
  always_comb begin
    w_occ_nxt = '0;
    for (int k = 0; k < DEPTH; k++) w_occ_nxt = w_occ_nxt + OCC_W'(w_valid_nxt[k]);
  end
  always_ff @(posedge Clk) r_occ <= w_occ_nxt;
  assign bus.OutValid       = g_stage[DEPTH-1].r_v;
  assign bus.OutInstruction = g_stage[DEPTH-1].r_d;
  assign bus.OutPCAddResult = g_stage[DEPTH-1].r_p;
  assign bus.Occupancy      = r_occ;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] r_stall, r_flush;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall <= '0;
      r_flush <= '0;
    end else begin
      if (bus.Flush && r_flush != '1) r_flush <= r_flush + 32'd1;
      if (!bus.Flush && !bus.StageWrite && r_occ != '0 && r_stall != '1) r_stall <= r_stall + 32'd1;
    end
  end
  assign bus.StallCount = r_stall;
  assign bus.FlushCount = r_flush;
`endif
endmodule

// File: tb/tb_pipe_stage_register.sv
// tb_pipe_stage_register: queue-based reference model feeding a scoreboard checked by an independent monitor
module tb_pipe_stage_register;
  localparam int          DEPTH = 3;
  localparam logic [31:0] NOP   = 32'hDEAD_0013;
  typedef struct { logic v; logic [31:0] d; logic [31:0] p; } ent_t;
  typedef struct { logic v; logic [31:0] d; logic [31:0] p; int occ; logic [31:0] sc; logic [31:0] fc; } exp_t;
  logic Clk = 1'b0, Reset = 1'b1;
  int checks = 0, errors = 0;
  ent_t mq[$];
  exp_t exp_q[$];
  logic [31:0] stall_cnt = 0, flush_cnt = 0;
  pipe_stage_register_if #(.DATA_W(32), .PC_W(32), .DEPTH(DEPTH)) bus ();
  pipe_stage_register #(.DATA_W(32), .PC_W(32), .DEPTH(DEPTH), .NOP_VALUE(NOP)) dut (
    .Clk(Clk), .Reset(Reset), .bus(bus)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input logic rst, input logic fl, input logic sw, input logic iv,
                     input logic [31:0] d, input logic [31:0] p);
    bit any;
    int occ;
    @(negedge Clk);
    Reset = rst; bus.Flush = fl; bus.StageWrite = sw; bus.InValid = iv;
    bus.InInstruction = d; bus.InPCAddResult = p;
    any = 0;
    foreach (mq[k]) if (mq[k].v) any = 1;
    if (rst) begin stall_cnt = 0; flush_cnt = 0; end
    else begin
      if (fl && flush_cnt != 32'hFFFF_FFFF) flush_cnt++;
      if (!fl && !sw && any && stall_cnt != 32'hFFFF_FFFF) stall_cnt++;
    end
    if (rst || fl) begin
      mq.delete();
      repeat (DEPTH) mq.push_back('{1'b0, NOP, 32'h0});
    end else if (sw) begin
      mq.push_front('{iv, d, p});
      void'(mq.pop_back());
    end
    occ = 0;
    foreach (mq[k]) occ += int'(mq[k].v);
    exp_q.push_back('{mq[DEPTH-1].v, mq[DEPTH-1].d, mq[DEPTH-1].p, occ, stall_cnt, flush_cnt});
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("OutValid", 32'(bus.OutValid), 32'(e.v));
        chk("OutInstruction", bus.OutInstruction, e.d);
        chk("OutPCAddResult", bus.OutPCAddResult, e.p);
        chk("Occupancy", 32'(bus.Occupancy), 32'(e.occ));
`ifdef PIPE_STAGE_STATS_EN
        chk("StallCount", bus.StallCount, e.sc);
        chk("FlushCount", bus.FlushCount, e.fc);
`endif
      end
    end
  end
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin : driver
    bus.Flush = 0; bus.StageWrite = 0; bus.InValid = 0; bus.InInstruction = 0; bus.InPCAddResult = 0;
    repeat (DEPTH) mq.push_back('{1'b0, NOP, 32'h0});
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 32'h1234, 32'h8);
    cyc(0, 0, 1, 1, 32'h2002_0005, 32'h4);
    cyc(0, 0, 1, 1, 32'h11, 32'h10);
    cyc(0, 0, 1, 1, 32'h22, 32'h14);
    cyc(0, 0, 1, 1, 32'h33, 32'h18);
    repeat (4) cyc(0, 0, 0, 1, 32'hFF, 32'hFF);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 32'h44, 32'h20);
    cyc(0, 0, 1, 1, 32'h55, 32'h24);
    cyc(1, 1, 1, 1, 32'h66, 32'h28);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, (i % 2) == 0, 32'h70 + i, 32'h30 + 4 * i);
    repeat (4) cyc(0, 0, 1, 0, 32'hABCD, 32'h0);
    cyc(0, 0, 1, 1, 32'h77, 32'h40);
    cyc(0, 1, 1, 1, 32'h88, 32'h44);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(99) < 2, $urandom_range(99) < 5, $urandom_range(99) < 70,
          $urandom_range(1), $urandom, $urandom);
    cyc(1, 0, 0, 0, 0, 0);
    @(posedge Clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
